input_debounce_sync: RTL and testbench

//  Per-bit synchroniser, debouncer and edge detector for pad inputs.

---
 rtl/input_debounce_sync.sv | 102 ++++++++++
 tb/tb_input_debounce_sync.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/input_debounce_sync.sv
// Per-bit pad input synchroniser, debouncer and edge detector with a
// saturating count of accepted transitions across all bits.
`timescale 1ns/1ps
module input_debounce_sync #(
    parameter int unsigned WIDTH           = 4,
    parameter int unsigned SYNC_STAGES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned EVT_W           = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] din,
    input  logic             evt_clr,
    output logic [WIDTH-1:0] dout,
    output logic [WIDTH-1:0] rise,
    output logic [WIDTH-1:0] fall,
    output logic [EVT_W-1:0] evt_count
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES) + 1;
    localparam int unsigned POP_W = $clog2(WIDTH + 1);
    localparam int unsigned SUM_W = EVT_W + POP_W;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [SUM_W-1:0] EVT_MAX  = {{POP_W{1'b0}}, {EVT_W{1'b1}}};

    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q, sync_d;
    logic [WIDTH-1:0][CNT_W-1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0]                  dout_q, dout_d;
    logic [WIDTH-1:0]                  rise_q, rise_d;
    logic [WIDTH-1:0]                  fall_q, fall_d;
    logic [EVT_W-1:0]                  evt_q, evt_d;
    logic [WIDTH-1:0]                  s_c;
    logic [POP_W-1:0]                  pop_c;
    logic [SUM_W-1:0]                  sum_c;

    // Synchroniser shift chain; s_c is the only consumer of din.
    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], din};
        s_c    = sync_q[SYNC_STAGES-1];
    end

    // Debounce: a change is accepted after DEBOUNCE_CYCLES consecutive differing samples.
    always_comb begin
        cnt_d  = cnt_q;
        dout_d = dout_q;
        rise_d = '0;
        fall_d = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            if (s_c[b] == dout_q[b]) begin
                cnt_d[b] = '0;
            end else if (cnt_q[b] == CNT_LAST) begin
                cnt_d[b]  = '0;
                dout_d[b] = s_c[b];
                rise_d[b] = s_c[b];
                fall_d[b] = ~s_c[b];
            end else begin
                cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
        end
    end

    // Event counter: widened adder keeps the saturation compare exact; clear wins.
    always_comb begin
        pop_c = '0;
        for (int unsigned b = 0; b < WIDTH; b++) begin
            pop_c = pop_c + POP_W'(rise_d[b] | fall_d[b]);
        end
        sum_c = SUM_W'(evt_q) + SUM_W'(pop_c);
        evt_d = evt_q;
        if (evt_clr) begin
            evt_d = '0;
        end else if (sum_c > EVT_MAX) begin
            evt_d = EVT_W'(EVT_MAX);
        end else begin
            evt_d = EVT_W'(sum_c);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            cnt_q  <= '0;
            dout_q <= '0;
            rise_q <= '0;
            fall_q <= '0;
            evt_q  <= '0;
        end else begin
            sync_q <= sync_d;
            cnt_q  <= cnt_d;
            dout_q <= dout_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
            evt_q  <= evt_d;
        end
    end

    assign dout      = dout_q;
    assign rise      = rise_q;
    assign fall      = fall_q;
    assign evt_count = evt_q;

endmodule

// File: tb/tb_input_debounce_sync.sv
// Self-checking bench: three configurations driven from shared pad inputs and
// compared each cycle against a sample-history reference model.
`timescale 1ns/1ps
module tb_input_debounce_sync;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       evt_clr = 1'b0;
    logic [3:0] din = 4'h0;

    logic [3:0] d0, r0, f0, d1, r1, f1, d2, r2, f2;
    logic [7:0] e0, e2;
    logic [2:0] e1;

    int n_cmp = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    input_debounce_sync #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EVT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .din(din), .evt_clr(evt_clr),
        .dout(d0), .rise(r0), .fall(f0), .evt_count(e0));

    input_debounce_sync #(.WIDTH(4), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4), .EVT_W(3)) dut_sat (
        .clk(clk), .rst_n(rst_n), .din(din), .evt_clr(evt_clr),
        .dout(d1), .rise(r1), .fall(f1), .evt_count(e1));

    input_debounce_sync #(.WIDTH(4), .SYNC_STAGES(3), .DEBOUNCE_CYCLES(1), .EVT_W(8)) dut_fast (
        .clk(clk), .rst_n(rst_n), .din(din), .evt_clr(evt_clr),
        .dout(d2), .rise(r2), .fall(f2), .evt_count(e2));

    // Reference model: a level is accepted once the last DEB synchronised samples all differ from it.
    int unsigned sync_m [3] = '{2, 2, 3};
    int unsigned deb_m  [3] = '{4, 4, 1};
    int unsigned emax_m [3] = '{255, 7, 255};
    logic [3:0]  pipe   [3][3];
    logic [3:0]  shist  [3][4];
    logic [3:0]  md [3], mr [3], mf [3];
    int unsigned me [3];

    initial begin
        forever begin
            @(posedge clk or negedge rst_n);
            for (int m = 0; m < 3; m++) begin
                if (!rst_n) begin
                    for (int k = 0; k < 4; k++) shist[m][k] = 4'h0;
                    for (int k = 0; k < 3; k++) pipe[m][k] = 4'h0;
                    md[m] = 4'h0; mr[m] = 4'h0; mf[m] = 4'h0; me[m] = 0;
                end else begin
                    logic [3:0] s, acc;
                    int unsigned n;
                    s = pipe[m][sync_m[m]-1];
                    for (int k = 3; k > 0; k--) shist[m][k] = shist[m][k-1];
                    shist[m][0] = s;
                    acc = 4'h0;
                    for (int b = 0; b < 4; b++) begin
                        logic all_diff;
                        all_diff = 1'b1;
                        for (int k = 0; k < int'(deb_m[m]); k++)
                            if (shist[m][k][b] == md[m][b]) all_diff = 1'b0;
                        acc[b] = all_diff;
                    end
                    md[m] = (md[m] & ~acc) | (s & acc);
                    mr[m] = acc & md[m];
                    mf[m] = acc & ~md[m];
                    n = $countones(acc);
                    if (evt_clr) me[m] = 0;
                    else me[m] = (me[m] + n > emax_m[m]) ? emax_m[m] : me[m] + n;
                    for (int k = 2; k > 0; k--) pipe[m][k] = pipe[m][k-1];
                    pipe[m][0] = din;
                end
            end
        end
    end

    function automatic logic [63:0] dut_vec();
        return {4'h0, d0, r0, f0, e0, d1, r1, f1, 5'h0, e1, d2, r2, f2, e2};
    endfunction

    function automatic logic [63:0] model_vec();
        return {4'h0, md[0], mr[0], mf[0], 8'(me[0]),
                md[1], mr[1], mf[1], 5'h0, 3'(me[1]),
                md[2], mr[2], mf[2], 8'(me[2])};
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        din   = 4'hF;
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (dut_vec() !== 64'h0) begin
            n_fail++; $display("FAIL reset_hold got=%h want=0", dut_vec());
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL reset_model edge=%0d got=%h want=%h", e, dut_vec(), model_vec());
            end
            if (e == 4) begin
                n_cmp++;
                if ({d2, r2} !== 8'hFF) begin
                    n_fail++; $display("FAIL reset_fast_edge4 got=%h want=ff", {d2, r2});
                end
            end
            if (e == 5) begin
                n_cmp++;
                if (d0 !== 4'h0) begin
                    n_fail++; $display("FAIL reset_early got=%h want=0", d0);
                end
            end
            if (e == 6) begin
                n_cmp++;
                if ({d0, r0, e0} !== {4'hF, 4'hF, 8'd4}) begin
                    n_fail++; $display("FAIL reset_edge6 got=%h want=ff04", {d0, r0, e0});
                end
            end
            if (e == 7) begin
                n_cmp++;
                if (r0 !== 4'h0) begin
                    n_fail++; $display("FAIL reset_rise_width got=%h want=0", r0);
                end
            end
        end
    endtask

    task automatic test_glitch();
        logic [7:0] e_before;
        din = 4'h0;
        repeat (10) begin
            @(posedge clk); #1;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL glitch_settle got=%h want=%h", dut_vec(), model_vec());
            end
        end
        e_before = e0;
        din[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        din[0] = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({d0[0], r0[0]} !== 2'b00 || dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL glitch cyc=%0d got=%h want=%h", c, dut_vec(), model_vec());
            end
        end
        n_cmp++;
        if (e0 !== e_before) begin
            n_fail++; $display("FAIL glitch_evt got=%0d want=%0d", e0, e_before);
        end
    endtask

    task automatic test_latency();
        logic [7:0] e_start;
        e_start = e0;
        din[2] = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (r0[2] !== (k == 6) || dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL latency_rise edge=%0d got=%b want=%b", k, r0[2], k == 6);
            end
        end
        n_cmp++;
        if (e0 !== e_start + 8'd1) begin
            n_fail++; $display("FAIL latency_evt_rise got=%0d want=%0d", e0, e_start + 8'd1);
        end
        din[2] = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (f0[2] !== (k == 6) || dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL latency_fall edge=%0d got=%b want=%b", k, f0[2], k == 6);
            end
        end
        n_cmp++;
        if (e0 !== e_start + 8'd2) begin
            n_fail++; $display("FAIL latency_evt_fall got=%0d want=%0d", e0, e_start + 8'd2);
        end
    endtask

    task automatic test_saturation();
        logic [2:0] exp_sat [3] = '{3'd4, 3'd7, 3'd7};
        evt_clr = 1'b1;
        @(posedge clk); #1;
        evt_clr = 1'b0;
        n_cmp++;
        if (e1 !== 3'd0) begin
            n_fail++; $display("FAIL sat_clear got=%0d want=0", e1);
        end
        for (int i = 0; i < 3; i++) begin
            din = ~din;
            repeat (8) begin
                @(posedge clk); #1;
                n_cmp++;
                if (dut_vec() !== model_vec()) begin
                    n_fail++; $display("FAIL sat_model got=%h want=%h", dut_vec(), model_vec());
                end
            end
            n_cmp++;
            if (e1 !== exp_sat[i]) begin
                n_fail++; $display("FAIL sat_step%0d got=%0d want=%0d", i, e1, exp_sat[i]);
            end
        end
        din = ~din;
        repeat (5) @(posedge clk);
        #1;
        evt_clr = 1'b1;
        @(posedge clk); #1;
        evt_clr = 1'b0;
        n_cmp++;
        if ({d0, e0, e1} !== {din, 8'd0, 3'd0}) begin
            n_fail++; $display("FAIL sat_clr_wins got=%h want=%h", {d0, e0, e1}, {din, 11'd0});
        end
    endtask

    task automatic test_async_reset();
        din = 4'h8;
        repeat (10) @(posedge clk);
        #1;
        din = 4'hA;
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (dut_vec() !== 64'h0) begin
            n_fail++; $display("FAIL async_clear got=%h want=0", dut_vec());
        end
        rst_n = 1'b1;
        for (int e = 1; e <= 7; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if (d0 !== ((e >= 6) ? 4'hA : 4'h0) || dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL async_restart edge=%0d got=%h want=%h", e, d0, (e >= 6) ? 4'hA : 4'h0);
            end
        end
    endtask

    task automatic test_fast();
        rst_n = 1'b0;
        din   = 4'h0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        din = 4'h5;
        for (int e = 1; e <= 5; e++) begin
            @(posedge clk); #1;
            n_cmp++;
            if ({d2, r2} !== ((e == 4) ? 8'h55 : (e == 5) ? 8'h50 : 8'h00)) begin
                n_fail++; $display("FAIL fast edge=%0d got=%h want=%h", e, {d2, r2},
                                   (e == 4) ? 8'h55 : (e == 5) ? 8'h50 : 8'h00);
            end
        end
    endtask

    task automatic test_random();
        int hold = 0;
        for (int c = 0; c < 600; c++) begin
            if (hold == 0) begin
                din  = 4'($urandom);
                hold = $urandom_range(1, 9);
            end
            hold--;
            evt_clr = ($urandom_range(0, 15) == 0);
            @(posedge clk); #1;
            n_cmp++;
            if (dut_vec() !== model_vec()) begin
                n_fail++; $display("FAIL random cyc=%0d got=%h want=%h", c, dut_vec(), model_vec());
            end
            n_cmp++;
            if (((r0 & f0) | (r1 & f1) | (r2 & f2)) !== 4'h0) begin
                n_fail++; $display("FAIL random_excl cyc=%0d got=%h want=0", c, (r0 & f0) | (r1 & f1) | (r2 & f2));
            end
        end
        evt_clr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_glitch();
        test_latency();
        test_saturation();
        test_async_reset();
        test_fast();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
